// File: rtl/mole_scheduler_if.sv
// Player-side signals of the mole scheduler.
//   master: drives start/sw, observes the game outputs.
//   slave : the scheduler itself.
interface mole_scheduler_if;
  logic       start;
  logic [7:0] sw;
  logic [7:0] mole;
  logic [3:0] hit_count;
  logic [3:0] misses;
  logic [1:0] state;
  logic       game_over;

  modport master (
    output start, sw,
    input  mole, hit_count, misses, state, game_over
  );

  modport slave (
    input  start, sw,
    output mole, hit_count, misses, state, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: spawns moles from an LFSR, ages them, scores hits
// on switch toggles and counts misses until the game ends.
//   game_clk : game tick clock
//   rst      : synchronous, active-high reset
//   bus      : start/sw in; mole, hit_count, misses, state, game_over out
module mole_scheduler #(
  parameter int unsigned MOLE_LIFE  = 3,
  parameter int unsigned MAX_MISSES = 5,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic             game_clk,
  input logic             rst,
  mole_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam logic [1:0] AGE_LAST  = 2'(MOLE_LIFE - 1);
  localparam logic [4:0] MISS_LIMIT = 5'(MAX_MISSES);

  state_e          state_q, state_d;
  logic [7:0]      mole_q, mole_d;
  logic [7:0][1:0] age_q, age_d;
  logic [3:0]      hit_count_q, hit_count_d;
  logic [3:0]      misses_q, misses_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      sw_prev_q, sw_prev_d;

  logic [7:0] toggle, hit, whiff, expired;
  logic [4:0] miss_sum;
  logic [3:0] misses_sat;
  logic [7:0] lfsr_adv;
  logic [2:0] spawn_idx;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  always_comb begin
    sw_prev_d = bus.sw;
    toggle    = bus.sw ^ sw_prev_q;
    hit       = toggle & mole_q;
    whiff     = toggle & ~mole_q;
    for (int unsigned i = 0; i < 8; i++) begin
      expired[i] = mole_q[i] && (age_q[i] == AGE_LAST) && !hit[i];
    end

    miss_sum   = {1'b0, misses_q} + {1'b0, popcount8(expired)} + {1'b0, popcount8(whiff)};
    misses_sat = (miss_sum > 5'd15) ? 4'hF : miss_sum[3:0];

    lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_adv == '0) begin
      lfsr_adv = LFSR_SEED;
    end
    spawn_idx = lfsr_q[2:0];

    state_d     = state_q;
    mole_d      = '0;
    age_d       = '0;
    hit_count_d = '0;
    misses_d    = misses_q;
    lfsr_d      = lfsr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_PLAY;
          misses_d = '0;
        end
      end
      ST_PLAY: begin
        hit_count_d = popcount8(hit);
        misses_d    = misses_sat;
        lfsr_d      = lfsr_adv;
        mole_d      = mole_q & ~(hit | expired);
        for (int unsigned i = 0; i < 8; i++) begin
          if (mole_d[i]) begin
            age_d[i] = age_q[i] + 2'd1;
          end
        end
        if (!mole_q[spawn_idx] && !hit[spawn_idx] && !expired[spawn_idx]) begin
          mole_d[spawn_idx] = 1'b1;
          age_d[spawn_idx]  = '0;
        end
        if ({1'b0, misses_sat} >= MISS_LIMIT) begin
          state_d = ST_OVER;
          mole_d  = '0;
          age_d   = '0;
        end
      end
      ST_OVER: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    sw_prev_q <= sw_prev_d;
    if (rst) begin
      state_q     <= ST_IDLE;
      mole_q      <= '0;
      age_q       <= '0;
      hit_count_q <= '0;
      misses_q    <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      mole_q      <= mole_d;
      age_q       <= age_d;
      hit_count_q <= hit_count_d;
      misses_q    <= misses_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign bus.mole      = mole_q;
  assign bus.hit_count = hit_count_q;
  assign bus.misses    = misses_q;
  assign bus.state     = state_q;
  assign bus.game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_mole_scheduler.sv
module tb_mole_scheduler;

  localparam int MOLE_LIFE  = 3;
  localparam int MAX_MISSES = 5;
  localparam int SEED       = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mole_scheduler_if bus_if ();

  mole_scheduler #(
    .MOLE_LIFE (MOLE_LIFE),
    .MAX_MISSES(MAX_MISSES),
    .LFSR_SEED (8'hA5)
  ) dut (
    .game_clk(clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: each slot holds the number of lit ticks it has left (0 = dark).
  int m_life[8];
  int m_mode;   // 0 idle, 1 play, 2 over
  int m_misses;
  int m_hc;
  int m_lfsr;
  int m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_tick(input bit r, input bit s, input int w);
    int nl[8];
    int hits, whiffs, expires, idx, fb, tg;
    if (r) begin
      m_mode = 0; m_hc = 0; m_misses = 0; m_lfsr = SEED; m_prev = w;
      for (int i = 0; i < 8; i++) m_life[i] = 0;
      return;
    end
    case (m_mode)
      0: begin
        m_hc = 0;
        if (s) begin m_mode = 1; m_misses = 0; end
      end
      1: begin
        hits = 0; whiffs = 0; expires = 0;
        for (int i = 0; i < 8; i++) begin
          tg = ((w ^ m_prev) >> i) & 1;
          nl[i] = 0;
          if (tg == 1 && m_life[i] > 0) hits++;
          else if (tg == 1) whiffs++;
          else if (m_life[i] == 1) expires++;
          else if (m_life[i] > 1) nl[i] = m_life[i] - 1;
        end
        idx = m_lfsr % 8;
        if (m_life[idx] == 0) nl[idx] = MOLE_LIFE;
        m_misses = m_misses + whiffs + expires;
        if (m_misses > 15) m_misses = 15;
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr * 2) + fb) % 256;
        if (m_lfsr == 0) m_lfsr = SEED;
        m_hc = hits;
        if (m_misses >= MAX_MISSES) begin
          m_mode = 2;
          for (int i = 0; i < 8; i++) nl[i] = 0;
        end
        for (int i = 0; i < 8; i++) m_life[i] = nl[i];
      end
      default: begin
        m_hc = 0;
        if (!s) m_mode = 0;
      end
    endcase
    m_prev = w;
  endtask

  function automatic int model_mole();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_life[i] > 0) v += (1 << i);
    return v;
  endfunction

  task automatic step(input bit r, input bit s, input logic [7:0] w);
    @(negedge clk);
    rst = r;
    bus_if.start = s;
    bus_if.sw = w;
    @(posedge clk);
    cyc++;
    model_tick(r, s, int'(w));
    #1;
    chk("mole",      32'(bus_if.mole),      32'(model_mole()));
    chk("hit_count", 32'(bus_if.hit_count), 32'(m_hc));
    chk("misses",    32'(bus_if.misses),    32'(m_misses));
    chk("state",     32'(bus_if.state),     32'(m_mode));
    chk("game_over", 32'(bus_if.game_over), 32'(m_mode == 2));
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.sw = 8'h00;
    for (int i = 0; i < 8; i++) m_life[i] = 0;
    m_mode = 0; m_misses = 0; m_hc = 0; m_lfsr = SEED; m_prev = 0;

    // Game A: reset, spawn, hit, expiry, hit-over-expiry, game over.
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    chk("rst_state", 32'(bus_if.state), 0);
    chk("rst_mole", 32'(bus_if.mole), 0);
    chk("rst_misses", 32'(bus_if.misses), 0);
    chk("rst_go", 32'(bus_if.game_over), 0);
    step(0, 1, 8'h00);
    chk("start_play", 32'(bus_if.state), 1);
    step(0, 0, 8'h00);
    chk("first_spawn", 32'(bus_if.mole), 32'h20);
    chk("first_hc", 32'(bus_if.hit_count), 0);
    step(0, 0, 8'h20);
    chk("hit_hc", 32'(bus_if.hit_count), 1);
    chk("hit_mole", 32'(bus_if.mole), 32'h04);
    chk("hit_misses", 32'(bus_if.misses), 0);
    step(0, 0, 8'h20);
    chk("p3_mole", 32'(bus_if.mole), 32'h24);
    step(0, 0, 8'h20);
    chk("p4_mole", 32'(bus_if.mole), 32'h24);
    step(0, 0, 8'h20);
    chk("expire_mole", 32'(bus_if.mole), 32'h30);
    chk("expire_misses", 32'(bus_if.misses), 1);
    step(0, 0, 8'h20);
    chk("p6_mole", 32'(bus_if.mole), 32'h12);
    chk("p6_misses", 32'(bus_if.misses), 2);
    step(0, 0, 8'h20);
    chk("p7_mole", 32'(bus_if.mole), 32'h1A);
    step(0, 0, 8'h20);
    chk("p8_mole", 32'(bus_if.mole), 32'h8A);
    chk("p8_misses", 32'(bus_if.misses), 3);
    step(0, 0, 8'h20);
    chk("p9_mole", 32'(bus_if.mole), 32'hC8);
    chk("p9_misses", 32'(bus_if.misses), 4);
    step(0, 0, 8'h29);   // hit on expiring slot 3 plus whiff on slot 0
    chk("over_hc", 32'(bus_if.hit_count), 1);
    chk("over_misses", 32'(bus_if.misses), 5);
    chk("over_state", 32'(bus_if.state), 2);
    chk("over_go", 32'(bus_if.game_over), 1);
    chk("over_mole", 32'(bus_if.mole), 0);
    step(0, 1, 8'h29);
    step(0, 1, 8'h29);
    chk("over_hold", 32'(bus_if.state), 2);
    chk("over_hc0", 32'(bus_if.hit_count), 0);
    step(0, 0, 8'h29);
    chk("back_idle", 32'(bus_if.state), 0);
    chk("idle_misses", 32'(bus_if.misses), 5);
    step(0, 0, 8'h29);
    step(0, 1, 8'h29);
    chk("replay_misses", 32'(bus_if.misses), 0);
    step(0, 0, 8'h29);
    step(0, 0, 8'h29);

    // Game B: whiffs, then reset in the middle of play.
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    chk("b_spawn", 32'(bus_if.mole), 32'h20);
    step(0, 0, 8'h03);
    chk("whiff_misses", 32'(bus_if.misses), 2);
    chk("whiff_hc", 32'(bus_if.hit_count), 0);
    chk("whiff_mole", 32'(bus_if.mole), 32'h24);
    step(0, 0, 8'h83);
    chk("pre_rst_mole", 32'(bus_if.mole), 32'h24);
    chk("pre_rst_misses", 32'(bus_if.misses), 3);
    step(1, 0, 8'h83);
    chk("mid_rst_mole", 32'(bus_if.mole), 0);
    chk("mid_rst_misses", 32'(bus_if.misses), 0);
    chk("mid_rst_state", 32'(bus_if.state), 0);
    chk("mid_rst_hc", 32'(bus_if.hit_count), 0);
    step(0, 1, 8'h83);
    step(0, 0, 8'h83);
    chk("seed_reload", 32'(bus_if.mole), 32'h20);
    step(0, 0, 8'h83);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
